// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// 4-bit lookahead groups feed a flattened second-level lookahead across groups.
module pipelined_cla_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NG = WIDTH / 4;

  if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_width_check
    $error("pipelined_cla_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  // Group generate of one 4-bit group.
  function automatic logic group_gen(input logic [3:0] p, input logic [3:0] g);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  // Carry into group k as one sum of products over all lower groups (no ripple).
  function automatic logic group_carry(input logic [NG-1:0] gp, input logic [NG-1:0] gg,
                                       input logic c0, input int k);
    logic acc;
    logic term;
    acc = c0;
    for (int m = 0; m < k; m++) acc = acc & gp[m];
    for (int j = 0; j < k; j++) begin
      term = gg[j];
      for (int m = j + 1; m < k; m++) term = term & gp[m];
      acc = acc | term;
    end
    return acc;
  endfunction

  // ---- Stage 0: effective operands, bit and group propagate/generate ----
  logic [WIDTH-1:0] bb_p0;
  logic [WIDTH-1:0] p_p0;
  logic [WIDTH-1:0] g_p0;
  logic [NG-1:0]    gp_p0;
  logic [NG-1:0]    gg_p0;
  logic             c0_p0;

  always_comb begin
    bb_p0 = sub ? ~b : b;
    c0_p0 = cin ^ sub;
    p_p0  = a ^ bb_p0;
    g_p0  = a & bb_p0;
    gp_p0 = '0;
    gg_p0 = '0;
    for (int k = 0; k < NG; k++) begin
      gp_p0[k] = &p_p0[4*k +: 4];
      gg_p0[k] = group_gen(p_p0[4*k +: 4], g_p0[4*k +: 4]);
    end
  end

  // ---- Stage 1 registers ----
  logic [WIDTH-1:0] p_p1;
  logic [WIDTH-1:0] g_p1;
  logic [NG-1:0]    gp_p1;
  logic [NG-1:0]    gg_p1;
  logic             c0_p1;
  logic             vld_p1;

  logic adv_out;
  logic adv_s1;

  assign adv_out  = !out_valid | out_ready;
  assign adv_s1   = !vld_p1 | adv_out;
  assign in_ready = !rst & adv_s1;

  // ---- Stage 2: group carries, intra-group carries, sum ----
  logic [NG:0]      cg_p1;
  logic [WIDTH:0]   c_p1;
  logic [WIDTH-1:0] sum_p1;

  always_comb begin
    cg_p1 = '0;
    for (int k = 0; k <= NG; k++) cg_p1[k] = group_carry(gp_p1, gg_p1, c0_p1, k);
    c_p1 = '0;
    for (int k = 0; k < NG; k++) begin
      c_p1[4*k]   = cg_p1[k];
      c_p1[4*k+1] = g_p1[4*k] | (p_p1[4*k] & cg_p1[k]);
      c_p1[4*k+2] = g_p1[4*k+1] | (p_p1[4*k+1] & g_p1[4*k])
                  | (p_p1[4*k+1] & p_p1[4*k] & cg_p1[k]);
      c_p1[4*k+3] = g_p1[4*k+2] | (p_p1[4*k+2] & g_p1[4*k+1])
                  | (p_p1[4*k+2] & p_p1[4*k+1] & g_p1[4*k])
                  | (p_p1[4*k+2] & p_p1[4*k+1] & p_p1[4*k] & cg_p1[k]);
    end
    c_p1[WIDTH] = cg_p1[NG];
    sum_p1      = p_p1 ^ c_p1[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      p_p1      <= '0;
      g_p1      <= '0;
      gp_p1     <= '0;
      gg_p1     <= '0;
      c0_p1     <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      // A bubble is loaded into S1 whenever it advances without an offer.
      if (adv_s1) begin
        vld_p1 <= in_valid;
        p_p1   <= p_p0;
        g_p1   <= g_p0;
        gp_p1  <= gp_p0;
        gg_p1  <= gg_p0;
        c0_p1  <= c0_p0;
      end
      // ---- Output register ----
      if (adv_out) begin
        out_valid <= vld_p1;
        sum       <= sum_p1;
        cout      <= c_p1[WIDTH];
        overflow  <= c_p1[WIDTH] ^ c_p1[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed 16-bit cases, back-pressure, reset,
// exhaustive 4-bit and random 32-bit streams against an arithmetic reference.
module tb_pipelined_cla_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic        d16_in_valid, d16_in_ready, d16_cin, d16_sub, d16_out_valid, d16_out_ready;
  logic        d16_cout, d16_ovf;
  logic [15:0] d16_a, d16_b, d16_sum;

  logic        d4_in_valid, d4_in_ready, d4_cin, d4_sub, d4_out_valid, d4_out_ready;
  logic        d4_cout, d4_ovf;
  logic [3:0]  d4_a, d4_b, d4_sum;

  logic        d32_in_valid, d32_in_ready, d32_cin, d32_sub, d32_out_valid, d32_out_ready;
  logic        d32_cout, d32_ovf;
  logic [31:0] d32_a, d32_b, d32_sum;

  pipelined_cla_adder #(.WIDTH(16)) u_d16 (
    .clk(clk), .rst(rst), .in_valid(d16_in_valid), .in_ready(d16_in_ready),
    .a(d16_a), .b(d16_b), .cin(d16_cin), .sub(d16_sub),
    .out_valid(d16_out_valid), .out_ready(d16_out_ready),
    .sum(d16_sum), .cout(d16_cout), .overflow(d16_ovf)
  );

  pipelined_cla_adder #(.WIDTH(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(d4_in_valid), .in_ready(d4_in_ready),
    .a(d4_a), .b(d4_b), .cin(d4_cin), .sub(d4_sub),
    .out_valid(d4_out_valid), .out_ready(d4_out_ready),
    .sum(d4_sum), .cout(d4_cout), .overflow(d4_ovf)
  );

  pipelined_cla_adder #(.WIDTH(32)) u_d32 (
    .clk(clk), .rst(rst), .in_valid(d32_in_valid), .in_ready(d32_in_ready),
    .a(d32_a), .b(d32_b), .cin(d32_cin), .sub(d32_sub),
    .out_valid(d32_out_valid), .out_ready(d32_out_ready),
    .sum(d32_sum), .cout(d32_cout), .overflow(d32_ovf)
  );

  // Reference: plain unsigned and signed arithmetic on wide integers.
  function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub);
    res_t r;
    logic [63:0] mask;
    logic [63:0] full;
    longint sa, sb, sr, lim;
    mask = (64'd1 << w) - 64'd1;
    lim  = longint'(64'd1 << (w - 1));
    sa   = a[w-1] ? longint'(a) - longint'(mask) - 64'sd1 : longint'(a);
    sb   = b[w-1] ? longint'(b) - longint'(mask) - 64'sd1 : longint'(b);
    if (!sub) begin
      full   = a + b + 64'(cin);
      r.sum  = full & mask;
      r.cout = full[w];
      sr     = sa + sb + longint'(cin);
    end else begin
      r.sum  = (a - b - 64'(cin)) & mask;
      r.cout = (a >= (b + 64'(cin)));
      sr     = sa - sb - longint'(cin);
    end
    r.ovf = (sr >= lim) || (sr < -lim);
    return r;
  endfunction

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sub, output bit ok);
    int n = 0;
    @(posedge clk); #1;
    d16_a = a; d16_b = b; d16_cin = cin; d16_sub = sub; d16_in_valid = 1'b1;
    @(negedge clk);
    while (!d16_in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = (d16_in_ready === 1'b1);
    @(posedge clk); #1;
    d16_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    d16_in_valid = 1'b1; d16_a = 16'hAAAA; d16_b = 16'h5555; d16_cin = 1'b0; d16_sub = 1'b0;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (d16_in_ready !== 1'b0) begin
        fails++; $display("FAIL reset_in_ready: got %b want 0", d16_in_ready);
      end
      tests++;
      if ({d16_out_valid, d16_sum, d16_cout, d16_ovf} !== 19'd0) begin
        fails++; $display("FAIL reset_outputs: got v=%b s=%h c=%b o=%b want all 0",
                          d16_out_valid, d16_sum, d16_cout, d16_ovf);
      end
    end
    tests++;
    if ({d4_out_valid, d32_out_valid} !== 2'b00) begin
      fails++; $display("FAIL reset_other_valid: got %b want 00", {d4_out_valid, d32_out_valid});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    d16_in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (d16_in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_release_ready: got %b want 1", d16_in_ready);
    end
    repeat (2) begin
      @(negedge clk);
      tests++;
      if (d16_out_valid !== 1'b0) begin
        fails++; $display("FAIL reset_no_accept: got out_valid %b want 0", d16_out_valid);
      end
    end
  endtask

  task automatic test_directed();
    logic [15:0] ta [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    logic [15:0] tb_ [5] = '{16'h4321, 16'h0000, 16'h0001, 16'h0007, 16'h0001};
    logic        tc [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        ts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [17:0] want [5] = '{{16'h5555, 1'b0, 1'b0}, {16'h0000, 1'b1, 1'b0},
                              {16'h8000, 1'b0, 1'b1}, {16'hFFFE, 1'b0, 1'b0},
                              {16'h7FFF, 1'b1, 1'b1}};
    bit ok;
    d16_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      issue16(ta[i], tb_[i], tc[i], ts[i], ok);
      tests++;
      if (!ok) begin
        fails++; $display("FAIL directed_accept[%0d]: got in_ready 0 want 1", i);
      end
      @(negedge clk);
      tests++;
      if (d16_out_valid !== 1'b0) begin
        fails++; $display("FAIL directed_early[%0d]: got out_valid %b want 0", i, d16_out_valid);
      end
      @(negedge clk);
      tests++;
      if ({d16_out_valid, d16_sum, d16_cout, d16_ovf} !== {1'b1, want[i]}) begin
        fails++; $display("FAIL directed[%0d]: got v=%b s=%h c=%b o=%b want v=1 s=%h c=%b o=%b",
                          i, d16_out_valid, d16_sum, d16_cout, d16_ovf,
                          want[i][17:2], want[i][1], want[i][0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [6];
    logic [15:0] vb [6];
    logic        vc [6];
    logic        vs [6];
    res_t exq [$];
    res_t e;
    int sent = 0, got = 0, occ = 0, cyc = 0;
    bit held = 0, saw_full = 0;
    logic [17:0] prev = '0;
    for (int i = 0; i < 6; i++) begin
      va[i] = 16'($urandom); vb[i] = 16'($urandom);
      vc[i] = 1'($urandom); vs[i] = 1'($urandom);
    end
    while (got < 6 && cyc < 60) begin
      @(posedge clk); #1;
      if (sent < 6) begin
        d16_a = va[sent]; d16_b = vb[sent]; d16_cin = vc[sent]; d16_sub = vs[sent];
        d16_in_valid = 1'b1;
      end else begin
        d16_in_valid = 1'b0;
      end
      d16_out_ready = !(cyc >= 3 && cyc <= 6);
      @(negedge clk);
      tests++;
      if (d16_in_ready !== ((occ < 2) || d16_out_ready)) begin
        fails++; $display("FAIL bp_in_ready cyc%0d: got %b want %b", cyc, d16_in_ready,
                          ((occ < 2) || d16_out_ready));
      end
      if (held) begin
        tests++;
        if ({d16_sum, d16_cout, d16_ovf} !== prev) begin
          fails++; $display("FAIL bp_stable cyc%0d: got %h want %h", cyc,
                            {d16_sum, d16_cout, d16_ovf}, prev);
        end
      end
      held = d16_out_valid && !d16_out_ready;
      prev = {d16_sum, d16_cout, d16_ovf};
      if (occ == 2 && !d16_out_ready) saw_full = 1;
      if (d16_out_valid && d16_out_ready) begin
        tests++;
        if (exq.size() == 0) begin
          fails++; $display("FAIL bp_extra: got unexpected result %h want none", d16_sum);
        end else begin
          e = exq.pop_front();
          if ({d16_sum, d16_cout, d16_ovf} !== {e.sum[15:0], e.cout, e.ovf}) begin
            fails++; $display("FAIL bp_result[%0d]: got %h/%b/%b want %h/%b/%b", got,
                              d16_sum, d16_cout, d16_ovf, e.sum[15:0], e.cout, e.ovf);
          end
        end
        got++; occ--;
      end
      if (d16_in_valid && d16_in_ready) begin
        exq.push_back(model(16, 64'(d16_a), 64'(d16_b), d16_cin, d16_sub));
        sent++; occ++;
      end
      cyc++;
    end
    @(posedge clk); #1;
    d16_in_valid = 1'b0;
    d16_out_ready = 1'b1;
    tests++;
    if (got != 6 || exq.size() != 0 || !saw_full) begin
      fails++; $display("FAIL bp_complete: got %0d results full=%0d want 6 full=1", got, saw_full);
    end
  endtask

  task automatic test_reset_midstream();
    bit ok;
    d16_out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      d16_a = 16'(16'h0100 + i); d16_b = 16'h0003; d16_cin = 1'b0; d16_sub = 1'b0;
      d16_in_valid = 1'b1;
      @(negedge clk);
      tests++;
      if (d16_in_ready !== 1'b1) begin
        fails++; $display("FAIL mid_fill[%0d]: got in_ready %b want 1", i, d16_in_ready);
      end
    end
    @(posedge clk); #1;
    d16_in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (d16_in_ready !== 1'b0 || d16_out_valid !== 1'b1) begin
      fails++; $display("FAIL mid_before_rst: got ready=%b valid=%b want ready=0 valid=1",
                        d16_in_ready, d16_out_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({d16_out_valid, d16_sum, d16_cout, d16_ovf, d16_in_ready} !== 20'd1) begin
      fails++; $display("FAIL mid_after_rst: got v=%b s=%h c=%b o=%b rdy=%b want 0/0/0/0/1",
                        d16_out_valid, d16_sum, d16_cout, d16_ovf, d16_in_ready);
    end
    d16_out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (d16_out_valid !== 1'b0) begin
      fails++; $display("FAIL mid_flushed: got out_valid %b want 0", d16_out_valid);
    end
    issue16(16'h00FF, 16'h0101, 1'b0, 1'b0, ok);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (!ok || {d16_out_valid, d16_sum, d16_cout, d16_ovf} !== {1'b1, 16'h0200, 1'b0, 1'b0}) begin
      fails++; $display("FAIL mid_new_txn: got ok=%0d v=%b s=%h c=%b o=%b want 1/0200/0/0",
                        ok, d16_out_valid, d16_sum, d16_cout, d16_ovf);
    end
  endtask

  task automatic test_exhaustive_w4();
    res_t exq [$];
    res_t e;
    int sent = 0, got = 0, cyc = 0;
    bit acc = 0;
    logic [9:0] v;
    while (got < 1024 && cyc < 8000) begin
      @(posedge clk); #1;
      if (acc) d4_in_valid = 1'b0;
      if (!d4_in_valid && sent < 1024 && $urandom_range(0, 3) != 0) begin
        v = sent[9:0];
        d4_a = v[3:0]; d4_b = v[7:4]; d4_cin = v[8]; d4_sub = v[9];
        d4_in_valid = 1'b1;
      end
      d4_out_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (d4_out_valid && d4_out_ready) begin
        tests++;
        if (exq.size() == 0) begin
          fails++; $display("FAIL w4_extra: got result %h want none", d4_sum);
        end else begin
          e = exq.pop_front();
          if ({d4_sum, d4_cout, d4_ovf} !== {e.sum[3:0], e.cout, e.ovf}) begin
            fails++; $display("FAIL w4_result[%0d]: got %h/%b/%b want %h/%b/%b", got,
                              d4_sum, d4_cout, d4_ovf, e.sum[3:0], e.cout, e.ovf);
          end
        end
        got++;
      end
      acc = d4_in_valid && d4_in_ready;
      if (acc) begin
        exq.push_back(model(4, 64'(d4_a), 64'(d4_b), d4_cin, d4_sub));
        sent++;
      end
      cyc++;
    end
    @(posedge clk); #1;
    d4_in_valid = 1'b0;
    tests++;
    if (got != 1024 || exq.size() != 0) begin
      fails++; $display("FAIL w4_complete: got %0d results want 1024", got);
    end
  endtask

  task automatic test_random_w32();
    res_t exq [$];
    res_t e;
    int sent = 0, got = 0, cyc = 0;
    bit acc = 0;
    while (got < 10000 && cyc < 40000) begin
      @(posedge clk); #1;
      if (acc) d32_in_valid = 1'b0;
      if (!d32_in_valid && sent < 10000 && $urandom_range(0, 3) != 0) begin
        d32_a = $urandom; d32_b = $urandom;
        d32_cin = 1'($urandom); d32_sub = 1'($urandom);
        d32_in_valid = 1'b1;
      end
      d32_out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (d32_out_valid && d32_out_ready) begin
        tests++;
        if (exq.size() == 0) begin
          fails++; $display("FAIL w32_extra: got result %h want none", d32_sum);
        end else begin
          e = exq.pop_front();
          if ({d32_sum, d32_cout, d32_ovf} !== {e.sum[31:0], e.cout, e.ovf}) begin
            fails++; $display("FAIL w32_result[%0d]: got %h/%b/%b want %h/%b/%b", got,
                              d32_sum, d32_cout, d32_ovf, e.sum[31:0], e.cout, e.ovf);
          end
        end
        got++;
      end
      acc = d32_in_valid && d32_in_ready;
      if (acc) begin
        exq.push_back(model(32, 64'(d32_a), 64'(d32_b), d32_cin, d32_sub));
        sent++;
      end
      cyc++;
    end
    @(posedge clk); #1;
    d32_in_valid = 1'b0;
    tests++;
    if (got != 10000 || exq.size() != 0) begin
      fails++; $display("FAIL w32_complete: got %0d results want 10000", got);
    end
  endtask

  initial begin
    rst = 1'b1;
    d16_in_valid = 1'b0; d16_a = '0; d16_b = '0; d16_cin = 1'b0; d16_sub = 1'b0; d16_out_ready = 1'b1;
    d4_in_valid = 1'b0;  d4_a = '0;  d4_b = '0;  d4_cin = 1'b0;  d4_sub = 1'b0;  d4_out_ready = 1'b1;
    d32_in_valid = 1'b0; d32_a = '0; d32_b = '0; d32_cin = 1'b0; d32_sub = 1'b0; d32_out_ready = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midstream();
    test_exhaustive_w4();
    test_random_w32();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
